// File: rtl/packet_injector.sv
// packet_injector: buffers core-side flits in a small FIFO and serialises each one onto a
// single-bit line as a start bit (1) followed by the payload, LSB first, one bit per clock.
// The line idles at 0. Router backpressure (tx_busy) is honoured only when deciding to start a
// frame; a frame that has started always runs to completion.
// Build option: define INJECTOR_STATS_EN to enable the 16-bit completed-flit counter on
// sent_count. Without it, sent_count is tied to 0 and no counter register exists.
// The id parameter only identifies the node the statistics belong to.
module packet_injector #(
  parameter int unsigned id         = 0,
  parameter int unsigned FLIT_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FLIT_BITS-1:0] in_flit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_data,
  input  logic                 tx_busy,
  output logic [15:0]          sent_count
);

  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // One extra pointer bit distinguishes full from empty when the index bits match.
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned CntW  = (FLIT_BITS > 1) ? $clog2(FLIT_BITS) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(FLIT_BITS - 1);

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (id > 32'h7FFF_FFFF) begin : g_bad_id
    $error("id out of range");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData} state_e;

  state_e                 state_q, state_d;
  logic                   tx_data_q, tx_data_d;
  logic [FLIT_BITS-1:0]   shift_q, shift_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [FLIT_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic                   empty, full, push, pop, can_start;
  logic [FLIT_BITS-1:0]   head;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign head      = mem_q[rd_ptr_q[AddrW-1:0]];
  assign can_start = ~empty & ~tx_busy;
  assign tx_data   = tx_data_q;

  // FIFO storage: written on accepted pushes only; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= in_flit;
    end
  end

  // FIFO pointers; the index bits wrap naturally modulo FIFO_DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Serialiser state, line register, shift register and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tx_data_q <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: start decision in IDLE and at the end of each frame, payload shifting.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (can_start) begin
          pop       = 1'b1;
          shift_d   = head;
          tx_data_d = 1'b1;
          state_d   = StStart;
        end else begin
          tx_data_d = 1'b0;
        end
      end
      StStart: begin
        tx_data_d = shift_q[0];
        shift_d   = shift_q >> 1;
        cnt_d     = '0;
        state_d   = StData;
      end
      StData: begin
        if (cnt_q == LastBit) begin
          cnt_d = '0;
          // Chain straight into the next frame when allowed, so there is no idle gap.
          if (can_start) begin
            pop       = 1'b1;
            shift_d   = head;
            tx_data_d = 1'b1;
            state_d   = StStart;
          end else begin
            tx_data_d = 1'b0;
            state_d   = StIdle;
          end
        end else begin
          tx_data_d = shift_q[0];
          shift_d   = shift_q >> 1;
          cnt_d     = cnt_q + CntW'(1);
        end
      end
      default: begin
        tx_data_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

`ifdef INJECTOR_STATS_EN
  logic        frame_done;
  logic [15:0] sent_q;

  // The last payload bit completes on the edge that leaves DATA at the final count.
  assign frame_done = (state_q == StData) && (cnt_q == LastBit);
  assign sent_count = sent_q;

  // Completed-flit counter, wraps from 0xFFFF to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_q <= '0;
    end else if (frame_done) begin
      sent_q <= sent_q + 16'd1;
    end
  end
`else
  assign sent_count = 16'd0;
`endif

endmodule

// File: tb/tb_packet_injector.sv
// Self-checking bench for packet_injector (default parameters). The reference model tracks the
// buffered flits as a queue and the line as a queue of bits still to be shown; every clock the
// bench compares tx_data, in_ready and sent_count with the model.
module tb_packet_injector;

  localparam int Depth = 4;
  localparam int Bits  = 8;

  logic            clk;
  logic            reset;
  logic [Bits-1:0] in_flit;
  logic            in_valid;
  logic            in_ready;
  logic            tx_data;
  logic            tx_busy;
  logic [15:0]     sent_count;

  packet_injector dut (
    .clk       (clk),
    .reset     (reset),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .sent_count(sent_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [Bits-1:0] fifo_q[$];
  bit              line_q[$];
  bit              in_frame;
  bit              exp_tx;
  logic [15:0]     exp_cnt;

  function automatic logic [15:0] exp_sent();
`ifdef INJECTOR_STATS_EN
    return exp_cnt;
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    fifo_q.delete();
    line_q.delete();
    in_frame = 1'b0;
    exp_tx   = 1'b0;
    exp_cnt  = 16'd0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tx_data"},    {15'd0, tx_data},  {15'd0, exp_tx});
    chk({tag, ".in_ready"},   {15'd0, in_ready}, {15'd0, 1'(fifo_q.size() < Depth)});
    chk({tag, ".sent_count"}, sent_count,        exp_sent());
  endtask

  // One clock: drive inputs, advance the model across the edge, check 1 time unit later.
  task automatic tick(input bit valid, input logic [Bits-1:0] flit, input bit busy,
                      input string tag);
    bit accept;
    logic [Bits-1:0] f;
    in_valid = valid;
    in_flit  = flit;
    tx_busy  = busy;
    @(posedge clk);
    accept = valid && (fifo_q.size() < Depth);
    if (line_q.size() > 0) begin
      exp_tx = line_q.pop_front();
    end else begin
      if (in_frame) exp_cnt = exp_cnt + 16'd1;
      if (fifo_q.size() > 0 && !busy) begin
        f = fifo_q.pop_front();
        exp_tx = 1'b1;
        for (int i = 0; i < Bits; i++) line_q.push_back(f[i]);
        in_frame = 1'b1;
      end else begin
        exp_tx   = 1'b0;
        in_frame = 1'b0;
      end
    end
    if (accept) fifo_q.push_back(flit);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b0;
    in_valid = 1'b0;
    tx_busy  = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  bit a5_pattern[10];
  logic [15:0] cnt_before;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_flit  = '0;
    tx_busy  = 1'b0;
    model_clear();

    // Reset state.
    #2;
    check_all("reset");
    do_reset("reset_hold");
    tick(0, 8'h00, 0, "post_reset");

    // Single flit 0xA5: start bit then payload LSB first, then idle.
    a5_pattern = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0};
    tick(1, 8'hA5, 0, "a5_push");
    for (int k = 0; k < 10; k++) begin
      tick(0, 8'h00, 0, "a5_frame");
      chk("a5_bit", {15'd0, tx_data}, {15'd0, a5_pattern[k]});
    end
`ifdef INJECTOR_STATS_EN
    chk("a5_sent", sent_count, 16'd1);
`else
    chk("a5_sent", sent_count, 16'd0);
`endif

    // Back-to-back 0x01 then 0x80: 18 frame bits with no idle gap.
    cnt_before = exp_sent();
    tick(1, 8'h01, 0, "b2b_push0");
    tick(1, 8'h80, 0, "b2b_push1");
    for (int k = 0; k < 22; k++) tick(0, 8'h00, 0, "b2b_frames");
`ifdef INJECTOR_STATS_EN
    chk("b2b_sent", sent_count, cnt_before + 16'd2);
`else
    chk("b2b_sent", sent_count, 16'd0);
`endif

    // Fill under backpressure: 5 pushes, 5th dropped, line stays idle; then drain 4 frames.
    for (int k = 0; k < 5; k++) tick(1, 8'($urandom), 1, "fill_push");
    chk("fill_ready", {15'd0, in_ready}, 16'd0);
    for (int k = 0; k < 4; k++) tick(0, 8'h00, 1, "fill_hold");
    for (int k = 0; k < 42; k++) tick(0, 8'h00, 0, "fill_drain");

    // Busy raised mid-frame: frame completes, next frame waits for busy to drop.
    tick(1, 8'($urandom), 0, "midbusy_push0");
    tick(1, 8'($urandom), 0, "midbusy_push1");
    for (int k = 0; k < 4; k++) tick(0, 8'h00, 0, "midbusy_lead");
    for (int k = 0; k < 10; k++) tick(0, 8'h00, 1, "midbusy_busy");
    chk("midbusy_idle", {15'd0, tx_data}, 16'd0);
    for (int k = 0; k < 12; k++) tick(0, 8'h00, 0, "midbusy_resume");

    // Reset at payload bit 4 with two flits queued; nothing follows until a new push.
    tick(1, 8'($urandom), 0, "rst_push0");
    tick(1, 8'($urandom), 0, "rst_push1");
    tick(1, 8'($urandom), 0, "rst_push2");
    for (int k = 0; k < 4; k++) tick(0, 8'h00, 0, "rst_lead");
    do_reset("rst_mid");
    for (int k = 0; k < 12; k++) tick(0, 8'h00, 0, "rst_after");

    // Randomised traffic with occasional backpressure.
    for (int k = 0; k < 600; k++) begin
      tick(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0), "rand");
    end
    for (int k = 0; k < 60; k++) tick(0, 8'h00, 0, "rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
